// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned operands, a full-width
// product and zero/negative/overflow status, one iteration per clock.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     ra,
    input  logic [WIDTH-1:0]     rb,
    output logic [2*WIDTH-1:0]   res,
    output logic [7:0]           flags,
    output logic                 busy,
    output logic                 done
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    // A signed product fits in WIDTH bits only when bits [PW-1:WIDTH-1] are all equal.
    localparam logic [PW-1:0] SIGN_RUN = {{(WIDTH-1){1'b0}}, {(WIDTH+1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [PW-1:0]       mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]       acc_q,    acc_d;
    logic                negate_q, negate_d;
    logic                smode_q,  smode_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [PW-1:0]       res_q,    res_d;
    logic [7:0]          flags_q,  flags_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [PW-1:0]       partial_sum;
    logic [PW-1:0]       product;

    function automatic logic [7:0] calc_flags(input logic [PW-1:0] p, input logic sm);
        logic [PW-1:0] upper;
        logic          ovf;
        upper = p >> (WIDTH - 1);
        if (sm) begin
            ovf = (upper != '0) && (upper != SIGN_RUN);
        end else begin
            ovf = (p >> WIDTH) != '0;
        end
        return {5'b00000, ovf, sm & p[PW-1], p == '0};
    endfunction

    // Magnitudes are taken as unsigned WIDTH-bit values, so the most-negative
    // operand maps to 2**(WIDTH-1) without loss.
    always_comb begin
        a_neg = signed_mode & ra[WIDTH-1];
        b_neg = signed_mode & rb[WIDTH-1];
        a_mag = a_neg ? -ra : ra;
        b_mag = b_neg ? -rb : rb;
    end

    always_comb begin
        partial_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        product     = negate_q ? -partial_sum : partial_sum;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        negate_d = negate_q;
        smode_d  = smode_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = CALC;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    negate_d = a_neg ^ b_neg;
                    smode_d  = signed_mode;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                end
            end
            CALC: begin
                acc_d    = partial_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    res_d   = product;
                    flags_d = calc_flags(product, smode_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            negate_q <= 1'b0;
            smode_q  <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            negate_q <= negate_d;
            smode_q  <= smode_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign res   = res_q;
    assign flags = flags_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances, directed corners,
// back-to-back starts, mid-operation reset and random operands vs an arithmetic model.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start4 = 1'b0, sm4 = 1'b0;
    logic [3:0] ra4 = '0, rb4 = '0;
    logic [7:0] res4;
    logic [7:0] flags4;
    logic       busy4, done4;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  ra8 = '0, rb8 = '0;
    logic [15:0] res8;
    logic [7:0]  flags8;
    logic        busy8, done8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Entry layout: {done edge[23:0], flags[7:0], res[15:0]}
    logic [47:0] exp4_q[$];
    logic [47:0] exp8_q[$];
    logic [23:0] last4 = '0;
    logic [23:0] last8 = '0;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .ra(ra4), .rb(rb4), .res(res4), .flags(flags4), .busy(busy4), .done(done4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .ra(ra8), .rb(rb8), .res(res8), .flags(flags8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product computed with plain integer arithmetic; returns {flags, res}.
    function automatic logic [23:0] ref_model(input int w, input bit sm, input int a_raw, input int b_raw);
        longint mask, a, b, p, lo, hi;
        logic [15:0] r;
        logic [7:0]  f;
        mask = (longint'(1) << w) - 1;
        a = longint'(a_raw) & mask;
        b = longint'(b_raw) & mask;
        if (sm && a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
        if (sm && b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
        p = a * b;
        r = 16'(p & ((longint'(1) << (2 * w)) - 1));
        if (sm) begin
            lo = -(longint'(1) << (w - 1));
            hi = (longint'(1) << (w - 1)) - 1;
        end else begin
            lo = 0;
            hi = mask;
        end
        f = {5'b00000, (p < lo) || (p > hi), sm && (p < 0), p == 0};
        return {f, r};
    endfunction

    // Drives one start pulse; returns just after the capture edge E.
    task automatic issue(input int w, input bit sm, input int a, input int b);
        @(negedge clk);
        if (w == 4) begin
            start4 = 1'b1; sm4 = sm; ra4 = a[3:0]; rb4 = b[3:0];
        end else begin
            start8 = 1'b1; sm8 = sm; ra8 = a[7:0]; rb8 = b[7:0];
        end
        @(posedge clk); #1;
        if (w == 4) begin
            exp4_q.push_back({24'(cyc + 4), ref_model(4, sm, a, b)});
            start4 = 1'b0;
        end else begin
            exp8_q.push_back({24'(cyc + 8), ref_model(8, sm, a, b)});
            start8 = 1'b0;
        end
    endtask

    task automatic wait_done(input int w);
        int i;
        i = 0;
        while (i < 200 && ((w == 4) ? exp4_q.size() : exp8_q.size()) != 0) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (((w == 4) ? exp4_q.size() : exp8_q.size()) != 0) begin
            failures++;
            $display("FAIL timeout_w%0d act=pending exp=done", w);
            if (w == 4) exp4_q.delete(); else exp8_q.delete();
        end
    endtask

    // Scoreboard monitors: pop on done, otherwise verify outputs hold during CALC.
    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst) begin
            if (done4) begin
                if (exp4_q.size() == 0) begin
                    check("done4_unexpected", 1, 0);
                end else begin
                    e = exp4_q.pop_front();
                    check("res4", res4, e[15:0]);
                    check("flags4", flags4, e[23:16]);
                    check("lat4", cyc, e[47:24]);
                    check("busy4_at_done", busy4, 0);
                    last4 = e[23:0];
                end
            end else if (busy4) begin
                check("hold4", {flags4, 8'h00, res4}, {last4[23:16], last4[15:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst) begin
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("done8_unexpected", 1, 0);
                end else begin
                    e = exp8_q.pop_front();
                    check("res8", res8, e[15:0]);
                    check("flags8", flags8, e[23:16]);
                    check("lat8", cyc, e[47:24]);
                    last8 = e[23:0];
                end
            end else if (busy8) begin
                check("hold8", {flags8, res8}, last8);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b2b_next;
        int b2b_k;

        // Reset state
        #3;
        check("rst_res4", res4, 0);
        check("rst_flags4", flags4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_res8", res8, 0);
        check("rst_busy8", busy8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 14*2 with cycle-by-cycle busy/done timing
        issue(4, 0, 4'hE, 4'h2);
        check("busy_e0", busy4, 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check("busy_mid", busy4, 1);
            check("done_mid", done4, 0);
        end
        @(posedge clk); #1;
        check("busy_e4", busy4, 0);
        check("done_e4", done4, 1);
        check("res_e4", res4, 8'h1C);
        check("flags_e4", flags4, 8'h04);
        @(posedge clk); #1;
        check("done_pulse_end", done4, 0);
        wait_done(4);

        issue(4, 1, 4'hE, 4'h2); wait_done(4);
        issue(4, 0, 4'h0, 4'hF); wait_done(4);
        issue(4, 1, 4'h8, 4'h8); wait_done(4);
        check("neg8sq_res", res4, 8'h40);
        check("neg8sq_flags", flags4, 8'h04);

        // Reset during iteration 2
        issue(4, 0, 4'h7, 4'h3);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_res", res4, 0);
        check("abort_flags", flags4, 0);
        exp4_q.delete();
        last4 = '0;
        last8 = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        issue(4, 1, 4'h5, 4'hD); wait_done(4);

        // Start held high with operands changing every cycle
        @(negedge clk);
        start4 = 1'b1;
        sm4 = 1'($urandom_range(0, 1)); ra4 = 4'($urandom); rb4 = 4'($urandom);
        @(posedge clk); #1;
        exp4_q.push_back({24'(cyc + 4), ref_model(4, sm4, int'(ra4), int'(rb4))});
        b2b_next = cyc + 5;
        b2b_k = 1;
        while (b2b_k < 6) begin
            @(negedge clk);
            sm4 = 1'($urandom_range(0, 1)); ra4 = 4'($urandom); rb4 = 4'($urandom);
            @(posedge clk); #1;
            if (cyc == b2b_next) begin
                exp4_q.push_back({24'(cyc + 4), ref_model(4, sm4, int'(ra4), int'(rb4))});
                b2b_next = cyc + 5;
                b2b_k++;
            end
        end
        start4 = 1'b0;
        wait_done(4);

        // WIDTH=8 corners then random operands
        issue(8, 1, 8'h80, 8'h80); wait_done(8);
        issue(8, 1, 8'h80, 8'h7F); wait_done(8);
        issue(8, 0, 8'hFF, 8'hFF); wait_done(8);
        issue(8, 1, 8'hFF, 8'h01); wait_done(8);
        for (int n = 0; n < 40; n++) begin
            issue(8, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            wait_done(8);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a multiply, sampled on the clk rising edge.
REQ-005 SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-006 SHALL have ports ra and rb, input, WIDTH bits each: multiplicand and multiplier.
REQ-007 SHALL have port res, output, 2*WIDTH bits: registered product.
REQ-008 SHALL have port flags, output, 8 bits: registered status, with bit0 zero, bit1 negative, bit2 overflow, and bits7:3 always 0.
REQ-009 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE, with IDLE as the reset state.
REQ-012 SHALL capture ra, rb and signed_mode into internal registers when start=1 is sampled in IDLE or DONE, then enter CALC with the iteration counter at 0.
REQ-013 SHALL ignore start while in CALC; changes on ra, rb or signed_mode during CALC SHALL NOT affect the result.
REQ-014 SHALL perform one shift-add iteration per cycle in CALC, for exactly WIDTH iterations.
REQ-015 SHALL, with start sampled at edge E, perform the final iteration at edge E+WIDTH; that edge SHALL load res and flags, enter DONE, and set done=1 for one cycle.
REQ-016 SHALL drive busy=1 exactly in state CALC, i.e. from edge E to edge E+WIDTH.
REQ-017 SHALL return from DONE to IDLE on the next edge unless start=1, in which case a new operation is captured (back-to-back, one cycle of DONE between operations).
REQ-018 SHALL, in signed mode, multiply operand magnitudes and negate the 2*WIDTH-bit product when the operand signs differ; the most-negative operand SHALL be handled correctly (e.g. -8*-8 = +64 for WIDTH=4).
REQ-019 SHALL, in unsigned mode, produce the zero-extended full 2*WIDTH-bit product; res SHALL never be truncated.
REQ-020 SHALL set flags bit0 = (res == 0).
REQ-021 SHALL set flags bit1 = signed_mode AND res[2*WIDTH-1]; it SHALL be 0 in unsigned mode.
REQ-022 SHALL set flags bit2 = 1 when the product does not fit in WIDTH bits, i.e. unsigned: res[2W-1:W] != 0; signed: res[2W-1:W-1] not all-equal.
REQ-023 SHALL hold res and flags stable from the DONE edge until the next completion; they SHALL NOT change during CALC.

Reset
REQ-024 SHALL, while rst=1 and regardless of clk, force state IDLE and set res=0, flags=8'h00, busy=0, done=0 and all internal registers to 0.
REQ-025 SHALL, when rst asserts mid-CALC, abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-026 SHALL cover WIDTH=4, unsigned, ra=4'b1110, rb=4'b0010, start at edge 0 -> busy high edges 0..4, done high for one cycle after edge 4, res=8'h1C, flags=8'h04.
REQ-027 SHALL cover WIDTH=4, signed, ra=4'b1110 (-2), rb=4'b0010 -> res=8'hFC, flags=8'h02.
REQ-028 SHALL cover WIDTH=4, signed, ra=rb=4'b1000 -> res=8'h40, flags=8'h04; and unsigned, ra=0, rb=4'hF -> res=8'h00, flags=8'h01.
REQ-029 SHALL cover start held high continuously with ra/rb toggled during CALC -> back-to-back operations every WIDTH+1 cycles, each result matching operands captured at its start edge.
REQ-030 SHALL cover rst pulsed at iteration 2 of a multiply -> busy, done, res and flags go to 0 immediately, no done pulse, and the next multiply is correct.
REQ-031 SHALL cover WIDTH=8 with random signed and unsigned operands against a reference product -> res, flags and latency (done at edge E+8) all match.
